t_ff_count_ctrl: RTL

//   Sequencer for an external bank of WIDTH T flip-flops. It reads the bank

---
 rtl/t_ff_count_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/t_ff_count_ctrl.sv
// Sequencer that drives the T inputs of an external flop bank so the bank
// counts modulo (MAX_COUNT+1) up or down, in free-run or one-shot mode.
module t_ff_count_ctrl #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic             mode,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] t_out,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  state_t           state, state_next;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] next_val;
  logic             term;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; combinational blocks below use blocking (=).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Counting arithmetic is taken from the bank's actual Q, so an
  // out-of-range value is pulled back into range on the next step.
  always_comb begin
    load_val = up_dn ? '0 : MAX_V;
    if (up_dn) begin
      next_val = (q_in >= MAX_V) ? '0 : q_in + ONE_V;
      term     = (q_in >= MAX_V);
    end else begin
      next_val = (q_in == '0 || q_in > MAX_V) ? MAX_V : q_in - ONE_V;
      term     = (q_in == '0);
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    t_out      = '0;
    tc         = 1'b0;
    unique case (state)
      IDLE: begin
        if (!stop && start) state_next = CLEAR;
      end
      CLEAR: begin
        if (stop) begin
          state_next = IDLE;
        end else begin
          t_out      = q_in ^ load_val;
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (!mode) begin
          t_out = q_in ^ next_val;
          tc    = term;
        end else if (term) begin
          // One-shot: leave the bank parked on the terminal value.
          tc         = 1'b1;
          state_next = DONE;
        end else begin
          t_out = q_in ^ next_val;
        end
      end
      DONE: begin
        if (stop)       state_next = IDLE;
        else if (start) state_next = CLEAR;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CLEAR) || (state == RUN);
  assign done = (state == DONE);

endmodule
